// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one external combinational ALU between two
// requesters. Round-robin (or fixed-priority) arbitration, one transaction in
// flight, registered operands and results giving a fixed 2-cycle latency.
module alu_share_arbiter #(
  parameter int XLEN  = 64,
  parameter int OPW   = 4,
  parameter bit RR_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  // port 0 request
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [OPW-1:0]  req0_op,
  // port 1 request
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  input  logic [OPW-1:0]  req1_op,
  // port 0 response
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_out,
  output logic            rsp0_zero,
  output logic            rsp0_err,
  // port 1 response
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_out,
  output logic            rsp1_zero,
  output logic            rsp1_err,
  // shared ALU
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [OPW-1:0]  alu_op,
  input  logic [XLEN-1:0] alu_out,
  input  logic            alu_zero,
  output logic            busy
);

  localparam logic [OPW-1:0] OP_ADD = OPW'(1);
  localparam logic [OPW-1:0] OP_CMP0 = OPW'(8);
  localparam logic [OPW-1:0] OP_CMP1 = OPW'(9);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            rr_ptr_q;
  logic            owner_q;
  logic            illegal_q;
  logic [XLEN-1:0] alu_a_q, alu_b_q;
  logic [OPW-1:0]  alu_op_q;
  logic [1:0]      rsp_valid_q, rsp_zero_q, rsp_err_q;
  logic [XLEN-1:0] rsp_out_q [2];

  logic            grant_valid_s;
  logic            grant_s;
  logic            rsp_hs_s;
  logic [XLEN-1:0] sel_a_s, sel_b_s;
  logic [OPW-1:0]  sel_op_s;
  logic            sel_illegal_s;
  logic [XLEN-1:0] res_out_s;
  logic            res_zero_s;

  // Operand mux for the current arbitration winner, plus result shaping:
  // illegal ops report zero output, and the zero flag is only meaningful for
  // the compare ops because the ALU leaves a stale flag for everything else.
  always_comb begin
    sel_a_s       = grant_s ? req1_a  : req0_a;
    sel_b_s       = grant_s ? req1_b  : req0_b;
    sel_op_s      = grant_s ? req1_op : req0_op;
    sel_illegal_s = (sel_op_s > OP_CMP1);
    res_out_s     = illegal_q ? '0 : alu_out;
    res_zero_s    = !illegal_q && ((alu_op_q == OP_CMP0) || (alu_op_q == OP_CMP1)) && alu_zero;
  end

  // Next-state, arbitration and request/response handshake decode.
  always_comb begin
    state_d       = state_q;
    grant_valid_s = 1'b0;
    grant_s       = 1'b0;
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    rsp_hs_s      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0_valid && req1_valid) begin
          grant_valid_s = 1'b1;
          grant_s       = RR_EN ? rr_ptr_q : 1'b0;
        end else if (req0_valid) begin
          grant_valid_s = 1'b1;
          grant_s       = 1'b0;
        end else if (req1_valid) begin
          grant_valid_s = 1'b1;
          grant_s       = 1'b1;
        end else begin
          grant_valid_s = 1'b0;
        end
        if (grant_valid_s) begin
          req0_ready = !grant_s;
          req1_ready = grant_s;
          state_d    = S_EXEC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: state_d = S_RESP;
      S_RESP: begin
        rsp_hs_s = owner_q ? rsp1_ready : rsp0_ready;
        if (rsp_hs_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture operands/owner on accept; an illegal op leaves the ALU op alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q  <= 1'b0;
      owner_q   <= 1'b0;
      illegal_q <= 1'b0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= OP_ADD;
    end else if (state_q == S_IDLE && grant_valid_s) begin
      rr_ptr_q  <= ~grant_s;
      owner_q   <= grant_s;
      illegal_q <= sel_illegal_s;
      alu_a_q   <= sel_a_s;
      alu_b_q   <= sel_b_s;
      if (!sel_illegal_s) begin
        alu_op_q <= sel_op_s;
      end
    end
  end

  // Result capture at the end of EXEC and valid clear on the owner's handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q  <= 2'b00;
      rsp_zero_q   <= 2'b00;
      rsp_err_q    <= 2'b00;
      rsp_out_q[0] <= '0;
      rsp_out_q[1] <= '0;
    end else if (state_q == S_EXEC) begin
      rsp_valid_q[owner_q] <= 1'b1;
      rsp_out_q[owner_q]   <= res_out_s;
      rsp_zero_q[owner_q]  <= res_zero_s;
      rsp_err_q[owner_q]   <= illegal_q;
    end else if (rsp_hs_s) begin
      rsp_valid_q[owner_q] <= 1'b0;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp0_valid = rsp_valid_q[0];
  assign rsp0_out   = rsp_out_q[0];
  assign rsp0_zero  = rsp_zero_q[0];
  assign rsp0_err   = rsp_err_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp1_out   = rsp_out_q[1];
  assign rsp1_zero  = rsp_zero_q[1];
  assign rsp1_err   = rsp_err_q[1];
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: behavioural shared ALU (with stale compare
// flag), per-port expected-result queues, one task per scenario.
module tb_alu_share_arbiter;

  typedef struct packed {
    logic [63:0] out;
    logic        zero;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [63:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
  logic        rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
  logic [63:0] rsp0_out, rsp1_out;
  logic [63:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_op;
  logic        alu_zero, alu_is_cmp;
  logic        busy;
  logic        stale_zero = 1'b0;

  int   checks = 0;
  int   errors = 0;
  exp_t exp0_q[$];
  exp_t exp1_q[$];
  logic [3:0] last_legal_op = 4'd1;

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_out(rsp0_out), .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_out(rsp1_out), .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out), .alu_zero(alu_zero),
    .busy(busy)
  );

  function automatic logic [63:0] alu_fn(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a + b;
      4'd2: r = a - b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << b[5:0];
      4'd6: r = a >> b[5:0];
      4'd7: r = $signed(a) >>> b[5:0];
      4'd8: r = a - b;
      4'd9: r = a - b;
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  function automatic logic cmp_fn(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    return (op == 4'd8) ? (a == b) : ($signed(a) < $signed(b));
  endfunction

  // Behavioural ALU: the compare flag only updates for ops 8/9, else stays stale.
  assign alu_out    = alu_fn(alu_op, alu_a, alu_b);
  assign alu_is_cmp = (alu_op == 4'd8) || (alu_op == 4'd9);
  assign alu_zero   = alu_is_cmp ? cmp_fn(alu_op, alu_a, alu_b) : stale_zero;
  always @(posedge clk) if (alu_is_cmp) stale_zero <= cmp_fn(alu_op, alu_a, alu_b);

  function automatic exp_t model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    e.out = 64'd0; e.zero = 1'b0; e.err = 1'b0;
    if (op > 4'd9) begin
      e.err = 1'b1;
    end else begin
      e.out = alu_fn(op, a, b);
      if (op == 4'd8 || op == 4'd9) e.zero = cmp_fn(op, a, b);
    end
    return e;
  endfunction

  // Drive a request on a port and push its expected response to that port's queue.
  task automatic drive_req(input bit port, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    if (!port) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
      exp0_q.push_back(model(op, a, b));
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
      exp1_q.push_back(model(op, a, b));
    end
    if (op <= 4'd9) last_legal_op = op;
  endtask

  task automatic test_reset();
    int seen;
    reset = 1'b1;
    req0_valid = 1'b0; req0_a = 64'd0; req0_b = 64'd0; req0_op = 4'd0;
    req1_valid = 1'b0; req1_a = 64'd0; req1_b = 64'd0; req1_op = 4'd0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || alu_op !== 4'd1 ||
        alu_a !== 64'd0 || rsp0_out !== 64'd0 || rsp1_err !== 1'b0 || req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got busy=%b v0=%b v1=%b op=%h a=%h out0=%h err1=%b rdy0=%b exp 0 0 0 1 0 0 0 0",
               busy, rsp0_valid, rsp1_valid, alu_op, alu_a, rsp0_out, rsp1_err, req0_ready);
    end
    // Accept a request, then reset while it is in EXEC.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_op = 4'd3; req0_a = 64'd1; req0_b = 64'd2;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1) begin errors++; $display("FAIL reset_accept got ready=%b exp 1", req0_ready); end
    @(posedge clk); #1;
    req0_valid = 1'b0; reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rsp0_valid !== 1'b0 || alu_op !== 4'd1) begin
      errors++;
      $display("FAIL reset_mid_exec got busy=%b v0=%b op=%h exp 0 0 1", busy, rsp0_valid, alu_op);
    end
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL reset_discard got %0d response cycles exp 0", seen); end
    last_legal_op = 4'd1;
  endtask

  task automatic test_single();
    exp_t e;
    @(posedge clk); #1;
    drive_req(1'b0, 4'd1, 64'd5, 64'd3);
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL single_ready got %b%b exp 10", req0_ready, req1_ready);
    end
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp0_valid !== 1'b0 || busy !== 1'b1 || alu_a !== 64'd5 || alu_b !== 64'd3 || alu_op !== 4'd1) begin
      errors++; $display("FAIL single_exec got v=%b busy=%b a=%h b=%h op=%h exp 0 1 5 3 1", rsp0_valid, busy, alu_a, alu_b, alu_op);
    end
    @(negedge clk);
    checks++;
    if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0) begin
      errors++; $display("FAIL single_latency got v0=%b v1=%b exp 1 0", rsp0_valid, rsp1_valid);
    end
    e = exp0_q.pop_front();
    checks++;
    if ({rsp0_out, rsp0_zero, rsp0_err} !== {e.out, e.zero, e.err} || rsp0_out !== 64'd8) begin
      errors++; $display("FAIL single_result got %h/%b/%b exp %h/%b/%b", rsp0_out, rsp0_zero, rsp0_err, e.out, e.zero, e.err);
    end
    @(negedge clk);
    checks++;
    if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_done got v0=%b busy=%b exp 0 0", rsp0_valid, busy);
    end
  endtask

  task automatic test_compare();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      drive_req(1'b1, (i == 0) ? 4'd8 : 4'd1, 64'd7, 64'd7);
      @(negedge clk);
      checks++;
      if (req1_ready !== 1'b1) begin errors++; $display("FAIL compare_ready[%0d] got %b exp 1", i, req1_ready); end
      @(posedge clk); #1 req1_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      e = exp1_q.pop_front();
      checks++;
      if (rsp1_valid !== 1'b1 || {rsp1_out, rsp1_zero, rsp1_err} !== {e.out, e.zero, e.err} ||
          rsp1_zero !== ((i == 0) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL compare_result[%0d] got v=%b %h/%b/%b exp 1 %h/%b/%b",
                           i, rsp1_valid, rsp1_out, rsp1_zero, rsp1_err, e.out, e.zero, e.err);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_contention();
    int   grants[$];
    int   gcyc[$];
    int   n0, n1, cyc;
    bit   g0, g1;
    exp_t e;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    n0 = 0; n1 = 0; cyc = 0;
    @(posedge clk); #1;
    drive_req(1'b0, 4'd1, 64'd100, 64'd1);
    drive_req(1'b1, 4'd2, 64'd3, 64'd5);
    while (grants.size() < 4 && cyc < 60) begin
      @(negedge clk);
      g0 = req0_valid && req0_ready;
      g1 = req1_valid && req1_ready;
      if (g0) begin grants.push_back(0); gcyc.push_back(cyc); end
      if (g1) begin grants.push_back(1); gcyc.push_back(cyc); end
      if (rsp0_valid) begin
        e = exp0_q.pop_front(); checks++;
        if ({rsp0_out, rsp0_zero, rsp0_err} !== {e.out, e.zero, e.err}) begin
          errors++; $display("FAIL contention_rsp0 got %h/%b/%b exp %h/%b/%b", rsp0_out, rsp0_zero, rsp0_err, e.out, e.zero, e.err);
        end
      end
      if (rsp1_valid) begin
        e = exp1_q.pop_front(); checks++;
        if ({rsp1_out, rsp1_zero, rsp1_err} !== {e.out, e.zero, e.err}) begin
          errors++; $display("FAIL contention_rsp1 got %h/%b/%b exp %h/%b/%b", rsp1_out, rsp1_zero, rsp1_err, e.out, e.zero, e.err);
        end
      end
      @(posedge clk); #1;
      if (g0) begin
        n0++;
        if (n0 < 2) drive_req(1'b0, 4'd4, 64'h00FF, 64'h0F0F); else req0_valid = 1'b0;
      end
      if (g1) begin
        n1++;
        if (n1 < 2) drive_req(1'b1, 4'd2, 64'd3, 64'd5); else req1_valid = 1'b0;
      end
      cyc++;
    end
    checks++;
    if (grants.size() != 4) begin
      errors++; $display("FAIL contention_timeout got %0d grants exp 4", grants.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (grants[i] != (i % 2)) begin
          errors++; $display("FAIL contention_order[%0d] got port %0d exp port %0d", i, grants[i], i % 2);
        end
        if (i > 0) begin
          checks++;
          if (gcyc[i] - gcyc[i-1] != 3) begin
            errors++; $display("FAIL contention_spacing[%0d] got %0d cycles exp 3", i, gcyc[i] - gcyc[i-1]);
          end
        end
      end
    end
    // Drain the last response.
    cyc = 0;
    while ((exp0_q.size() != 0 || exp1_q.size() != 0) && cyc < 20) begin
      @(negedge clk);
      if (rsp1_valid && exp1_q.size() != 0) begin
        e = exp1_q.pop_front(); checks++;
        if ({rsp1_out, rsp1_zero, rsp1_err} !== {e.out, e.zero, e.err} || rsp1_out !== 64'hFFFF_FFFF_FFFF_FFFE) begin
          errors++; $display("FAIL contention_last got %h/%b/%b exp %h/%b/%b", rsp1_out, rsp1_zero, rsp1_err, e.out, e.zero, e.err);
        end
      end
      if (rsp0_valid && exp0_q.size() != 0) e = exp0_q.pop_front();
      cyc++;
    end
    checks++;
    if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
      errors++; $display("FAIL contention_drain got %0d/%0d pending exp 0/0", exp0_q.size(), exp1_q.size());
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    exp_t        e;
    logic [63:0] held;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    @(posedge clk); #1;
    drive_req(1'b0, 4'd1, 64'd10, 64'd20);
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_accept got %b exp 1", req0_ready); end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    drive_req(1'b1, 4'd3, 64'hF0, 64'h0F);
    @(negedge clk);
    @(negedge clk);
    e = exp0_q.pop_front();
    held = rsp0_out;
    checks++;
    if (rsp0_valid !== 1'b1 || {rsp0_out, rsp0_zero, rsp0_err} !== {e.out, e.zero, e.err}) begin
      errors++; $display("FAIL bp_result got v=%b %h exp 1 %h", rsp0_valid, rsp0_out, e.out);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp0_valid !== 1'b1 || rsp0_out !== held || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b out=%h rdy=%b%b exp 1 %h 00", i, rsp0_valid, rsp0_out, req0_ready, req1_ready, held);
      end
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp0_valid !== 1'b0 || req1_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got v0=%b rdy1=%b exp 0 1", rsp0_valid, req1_ready);
    end
    rsp1_ready = 1'b1;
    @(posedge clk); #1 req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    e = exp1_q.pop_front();
    checks++;
    if (rsp1_valid !== 1'b1 || {rsp1_out, rsp1_zero, rsp1_err} !== {e.out, e.zero, e.err}) begin
      errors++; $display("FAIL bp_followup got v=%b %h exp 1 %h", rsp1_valid, rsp1_out, e.out);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    exp_t e;
    logic [3:0] op;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      op = (i == 0) ? 4'b1100 : 4'd7;
      @(posedge clk); #1;
      drive_req(1'b0, op, (i == 0) ? 64'd1 : 64'h8000_0000_0000_0000, (i == 0) ? 64'd2 : 64'd4);
      @(negedge clk);
      @(posedge clk); #1 req0_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (alu_op !== last_legal_op) begin
        errors++; $display("FAIL illegal_aluop[%0d] got %h exp %h", i, alu_op, last_legal_op);
      end
      @(negedge clk);
      e = exp0_q.pop_front();
      checks++;
      if (rsp0_valid !== 1'b1 || {rsp0_out, rsp0_zero, rsp0_err} !== {e.out, e.zero, e.err}) begin
        errors++; $display("FAIL illegal_result[%0d] got v=%b %h/%b/%b exp 1 %h/%b/%b",
                           i, rsp0_valid, rsp0_out, rsp0_zero, rsp0_err, e.out, e.zero, e.err);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_compare();
    test_contention();
    test_backpressure();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
